// File: rtl/instruction_queue.sv
// Instruction queue: 16-entry circular FIFO. The control unit pushes at most one decoded packet per cycle.
// Issue sees the oldest three entries combinationally and retires up to three of them per cycle.
module instruction_queue #(
  parameter int LOG_DEPTH          = 4,
  parameter int ALMOST_FULL_MARGIN = 2,
  parameter int ENTRY_W            = 107
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 queue_we,
  input  logic [1:0]           queue_instr_type,
  input  logic [13:0]          queue_arith_instr,
  input  logic [8:0]           queue_ram_instr,
  input  logic [9:0]           queue_ld_st_instr,
  input  logic [17:0]          cache_addr,
  input  logic [17:0]          main_mem_addr,
  input  logic [17:0]          d_cache_addr,
  input  logic [17:0]          d_main_mem_addr,
  output logic                 queue_full,
  output logic                 queue_almost_full,
  output logic [LOG_DEPTH:0]   count,
  output logic [ENTRY_W-1:0]   out_entry0,
  output logic [ENTRY_W-1:0]   out_entry1,
  output logic [ENTRY_W-1:0]   out_entry2,
  output logic [2:0]           out_valid,
  input  logic [1:0]           pop_count,
  output logic                 overflow_error,
  output logic                 underflow_error
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CW    = LOG_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(DEPTH - ALMOST_FULL_MARGIN);

  // Handshake: a push is taken on any edge where queue_we is high and space remains after this
  // cycle's pops. pop_count is a consume count: issue must only retire entries flagged in out_valid.
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d, underflow_q, underflow_d;
  logic [ENTRY_W-1:0]   entry_d;
  logic [CW-1:0]        pop_req, pop_eff, remain;
  logic                 push_ok;
  logic [LOG_DEPTH-1:0] rd_idx1, rd_idx2;

  always_comb begin
    entry_d  = {queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr,
                cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr};
    pop_req  = CW'(pop_count);
    pop_eff  = (pop_req > count_q) ? count_q : pop_req;
    remain   = count_q - pop_eff;
    push_ok  = queue_we && !flush && (remain < DEPTH_C);
    rd_ptr_d = rd_ptr_q + pop_eff[LOG_DEPTH-1:0];
    wr_ptr_d = wr_ptr_q + LOG_DEPTH'(push_ok);
    count_d  = remain + CW'(push_ok);
    // A flushed push is discarded on purpose and does not count as an overflow.
    overflow_d  = overflow_q | (queue_we && !flush && !push_ok);
    underflow_d = underflow_q | (pop_req > count_q);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (push_ok) mem_q[wr_ptr_q] <= entry_d;
    end
  end

  // Memory is never cleared; masking by out_valid keeps stale slots off the outputs.
  always_comb begin
    rd_idx1 = rd_ptr_q + LOG_DEPTH'(1);
    rd_idx2 = rd_ptr_q + LOG_DEPTH'(2);
    for (int i = 0; i < 3; i++) begin
      out_valid[i] = count_q > CW'(i);
    end
    out_entry0 = out_valid[0] ? mem_q[rd_ptr_q] : '0;
    out_entry1 = out_valid[1] ? mem_q[rd_idx1]  : '0;
    out_entry2 = out_valid[2] ? mem_q[rd_idx2]  : '0;
  end

  assign count             = count_q;
  assign queue_full        = (count_q == DEPTH_C);
  assign queue_almost_full = (count_q >= AF_C);
  assign overflow_error    = overflow_q;
  assign underflow_error   = underflow_q;
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO between the control unit (push side, at most 1 entry/cycle) and the issue/dispatch stage (pop side, up to 3 entries/cycle).
- Stores fully decoded instruction packets with their resolved APU addresses and per-iteration address deltas.
- Presents the oldest three entries combinationally to issue.
- Provides full and almost-full back-pressure to the control unit, plus sticky error flags for overflow and underflow.

Parameters:
- LOG_DEPTH, 4: log2 of entry count; DEPTH = 16.
- ALMOST_FULL_MARGIN, 2: queue_almost_full asserts when count >= DEPTH - ALMOST_FULL_MARGIN.
- ENTRY_W, 107: packed entry width (fixed by the field list below; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (asserted on program abort/complete).
- queue_we  in  1  push strobe.
- queue_instr_type  in  2  instruction type.
- queue_arith_instr  in  14  arithmetic instruction body.
- queue_ram_instr  in  9  RAM instruction body.
- queue_ld_st_instr  in  10  load/store instruction body.
- cache_addr  in  18  cache address.
- main_mem_addr  in  18  main memory address.
- d_cache_addr  in  18  cache address delta per loop iteration.
- d_main_mem_addr  in  18  main memory address delta per loop iteration.
- queue_full  out  1  count == DEPTH.
- queue_almost_full  out  1  count >= DEPTH - ALMOST_FULL_MARGIN.
- count  out  LOG_DEPTH+1  current occupancy, 0..DEPTH.
- out_entry0/out_entry1/out_entry2  out  107 each  oldest, second-oldest, third-oldest entry.
- out_valid  out  3  thermometer code; bit i set iff count > i.
- pop_count  in  2  number of entries consumed this cycle, 0..3.
- overflow_error  out  1  sticky: a push was dropped.
- underflow_error  out  1  sticky: pop_count exceeded count.

Behaviour:
- Packing, MSB to LSB:
  - [106:105] type
  - [104:91] arith
  - [90:82] ram
  - [81:72] ld_st
  - [71:54] cache_addr
  - [53:36] main_mem_addr
  - [35:18] d_cache_addr
  - [17:0] d_main_mem_addr
- Storage: DEPTH x 107 register array; rd_ptr and wr_ptr are LOG_DEPTH bits; occupancy is held in a separate count register.
- Read path is combinational: out_entry_i = mem[rd_ptr + i] with the index taken mod DEPTH. out_entry_i must be all-zero whenever out_valid[i] = 0.
- Effective pop: pop_eff = min(pop_count, count). If pop_count > count, set underflow_error and pop only count entries.
- Push acceptance:
  - Push is accepted iff queue_we && !flush && (count - pop_eff) < DEPTH.
  - A pop in the same cycle therefore frees space for the push, so a full queue with pop_count >= 1 accepts the push.
  - A rejected push sets overflow_error; no state changes for that entry.
- Per clock edge:
  - rd_ptr += pop_eff.
  - On an accepted push, mem[wr_ptr] <= packed entry and wr_ptr += 1.
  - count <= count - pop_eff + accepted.
  - Pointers wrap modulo DEPTH.
- Latency: an entry pushed at edge N is visible on out_entry/out_valid immediately after edge N. Push-to-issue latency is 1 cycle.
- queue_full and queue_almost_full are combinational from the count register.
- flush has priority over push and pop at the same edge: rd_ptr = wr_ptr = count = 0. Error flags are not cleared by flush.
- Reset (asynchronous, any time, including mid-push or mid-pop):
  - rd_ptr, wr_ptr, count = 0; therefore out_valid = 0, out_entry* = 0, queue_full = 0, queue_almost_full = 0.
  - overflow_error = 0, underflow_error = 0.
  - Memory contents need not be cleared; the masking above guarantees zero outputs.
- Error flags are cleared only by reset.
- No state machine beyond pointer/count; all updates occur in a single clocked process with the asynchronous reset.

Test Plan:
- Reset then single push (type=2, arith=14'h1234, all addrs 0) -> next cycle count=1, out_valid=3'b001, out_entry0[104:91]=14'h1234, out_entry1=0, out_entry2=0.
- Push 5 entries with cache_addr 1..5, then pop_count=3 for one cycle -> count=2, out_entry0 cache_addr=4, out_entry1 cache_addr=5, out_valid=3'b011.
- Wrap-around: push 14 and pop 14 in steady state, then push 16 with no pops -> queue_full=1 at count=16, almost_full rose at count=14, out_entry0..2 hold the first three of the 16 in order.
- Full with simultaneous push and pop_count=1 -> count stays 16, overflow_error stays 0. Full with push and pop_count=0 -> count 16, overflow_error=1, oldest entry unchanged.
- count=1 with pop_count=3 -> count=0, underflow_error=1, out_valid=0.
- count=7 with flush and queue_we in the same cycle -> count=0, push discarded. Then assert reset asynchronously mid-cycle -> outputs zero before the next clock edge, errors cleared.
